// File: rtl/main_circuit_pkg.sv
// Shared encodings and helpers for the parking/charging/storage fee block.
package main_circuit_pkg;

  typedef enum logic [2:0] {
    CODE_IDLE   = 3'b000,
    CODE_FEE1   = 3'b001,
    CODE_FEE2   = 3'b010,
    CODE_FEE3   = 3'b011,
    CODE_TOTAL  = 3'b100,
    CODE_PARK   = 3'b101,
    CODE_CHANGE = 3'b110,
    CODE_DIAG   = 3'b111
  } code_e;

  localparam logic [3:0] TEMP_LIMIT = 4'd12;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/main_circuit_tariff_calc.sv
// One fee term: rate picked by strict threshold compare, times quantity, plus surcharge (saturating).
module tariff_calc
  import main_circuit_pkg::*;
(
  input  logic [3:0] sel_value,
  input  logic [3:0] threshold,
  input  logic [3:0] price_high,
  input  logic [3:0] price_low,
  input  logic [3:0] qty,
  input  logic [7:0] additional,
  output logic [7:0] fee
);

  logic [3:0] rate;
  logic [7:0] product;

  // 4x4 product never exceeds 225, so only the surcharge add can overflow.
  assign rate    = (sel_value > threshold) ? price_high : price_low;
  assign product = {4'b0, rate} * {4'b0, qty};
  assign fee     = sat_add8(product, additional);

endmodule

// File: rtl/main_circuit.sv
// Fee/payment/alarm block, all outputs registered (1-cycle latency, no backpressure).
// Define ALARM_LOCKOUT_EN to blank result and payment flags while any alarm is raised.
module main_circuit
  import main_circuit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] PRICE_1,
  input  logic [3:0] PRICE_2,
  input  logic [3:0] WEIGHT_THRESHOLD,
  input  logic [3:0] FAST_CHARGE_PRICE,
  input  logic [3:0] CHARGE_PRICE,
  input  logic [3:0] CHARGE_THRESHOLD,
  input  logic [3:0] HIGH_CAPACITY_PRICE,
  input  logic [3:0] SMALL_CAPACITY_PRICE,
  input  logic [3:0] CAPACITY_THRESHOLD,
  input  logic [3:0] PASSWORD,
  input  logic [3:0] WEIGHT,
  input  logic [3:0] temp,
  input  logic [7:0] firePosition,
  input  logic [3:0] duration,
  input  logic [3:0] power,
  input  logic [3:0] capacity,
  input  logic [3:0] user_password,
  input  logic [7:0] cash,
  input  logic [3:0] card_number,
  input  logic [7:0] PARK_SEQUENCE,
  input  logic [7:0] additional,
  input  logic [2:0] code,
  input  logic [3:0] hours,
  input  logic       reverse,
  output logic       password_matched,
  output logic       isPaidCash,
  output logic       isPaidCard,
  output logic [7:0] result,
  output logic [7:0] alarm_status
);

  logic [7:0] fee1, fee2, fee3, total, due;
  logic [7:0] result_n, alarm_n;
  logic       pm_n, cash_n, card_n, lock;

  tariff_calc u_fee1 (
    .sel_value(WEIGHT), .threshold(WEIGHT_THRESHOLD), .price_high(PRICE_2),
    .price_low(PRICE_1), .qty(hours), .additional(additional), .fee(fee1)
  );

  tariff_calc u_fee2 (
    .sel_value(power), .threshold(CHARGE_THRESHOLD), .price_high(FAST_CHARGE_PRICE),
    .price_low(CHARGE_PRICE), .qty(duration), .additional(additional), .fee(fee2)
  );

  tariff_calc u_fee3 (
    .sel_value(capacity), .threshold(CAPACITY_THRESHOLD), .price_high(HIGH_CAPACITY_PRICE),
    .price_low(SMALL_CAPACITY_PRICE), .qty(hours), .additional(additional), .fee(fee3)
  );

  assign total = sat_add8(sat_add8(fee1, fee2), fee3);

`ifdef ALARM_LOCKOUT_EN
  assign lock = |alarm_n;
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    pm_n    = (user_password == PASSWORD);
    alarm_n = (temp >= TEMP_LIMIT) ? 8'hFF : firePosition;

    case (code_e'(code))
      CODE_FEE1:               due = fee1;
      CODE_FEE2:               due = fee2;
      CODE_FEE3:               due = fee3;
      CODE_TOTAL, CODE_CHANGE: due = total;
      default:                 due = 8'h00;
    endcase

    cash_n = (due != 8'h00) && (cash >= due);
    card_n = (due != 8'h00) && !cash_n && (card_number != 4'h0);

    case (code_e'(code))
      CODE_FEE1:   result_n = fee1;
      CODE_FEE2:   result_n = fee2;
      CODE_FEE3:   result_n = fee3;
      CODE_TOTAL:  result_n = total;
      CODE_PARK:   result_n = reverse ? bit_rev8(PARK_SEQUENCE) : PARK_SEQUENCE;
      CODE_CHANGE: result_n = (cash >= total) ? (cash - total) : 8'h00;
      CODE_DIAG:   result_n = {pm_n, |alarm_n, cash_n, card_n, 4'b0};
      default:     result_n = 8'h00;
    endcase

    // A wrong password (or an alarm lockout) hides everything except the alarm itself.
    if (!pm_n || lock) begin
      result_n = 8'h00;
      cash_n   = 1'b0;
      card_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      password_matched <= 1'b0;
      isPaidCash       <= 1'b0;
      isPaidCard       <= 1'b0;
      result           <= 8'h00;
      alarm_status     <= 8'h00;
    end else begin
      password_matched <= pm_n;
      isPaidCash       <= cash_n;
      isPaidCard       <= card_n;
      result           <= result_n;
      alarm_status     <= alarm_n;
    end
  end

endmodule

// File: tb/tb_main_circuit.sv
// Directed + randomized bench for main_circuit against an arithmetic reference model.
module tb_main_circuit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] PRICE_1, PRICE_2, WEIGHT_THRESHOLD, FAST_CHARGE_PRICE, CHARGE_PRICE;
  logic [3:0] CHARGE_THRESHOLD, HIGH_CAPACITY_PRICE, SMALL_CAPACITY_PRICE;
  logic [3:0] CAPACITY_THRESHOLD, PASSWORD, WEIGHT;
  logic [3:0] temp, duration, power, capacity, user_password, card_number, hours;
  logic [7:0] firePosition, cash, PARK_SEQUENCE, additional;
  logic [2:0] code;
  logic       reverse;
  logic       password_matched, isPaidCash, isPaidCard;
  logic [7:0] result, alarm_status;

  int checks   = 0;
  int failures = 0;

  logic       exp_pm, exp_cash, exp_card;
  logic [7:0] exp_result, exp_alarm;

  main_circuit dut (
    .clk(clk), .rst(rst),
    .PRICE_1(PRICE_1), .PRICE_2(PRICE_2), .WEIGHT_THRESHOLD(WEIGHT_THRESHOLD),
    .FAST_CHARGE_PRICE(FAST_CHARGE_PRICE), .CHARGE_PRICE(CHARGE_PRICE),
    .CHARGE_THRESHOLD(CHARGE_THRESHOLD), .HIGH_CAPACITY_PRICE(HIGH_CAPACITY_PRICE),
    .SMALL_CAPACITY_PRICE(SMALL_CAPACITY_PRICE), .CAPACITY_THRESHOLD(CAPACITY_THRESHOLD),
    .PASSWORD(PASSWORD), .WEIGHT(WEIGHT), .temp(temp), .firePosition(firePosition),
    .duration(duration), .power(power), .capacity(capacity),
    .user_password(user_password), .cash(cash), .card_number(card_number),
    .PARK_SEQUENCE(PARK_SEQUENCE), .additional(additional), .code(code),
    .hours(hours), .reverse(reverse),
    .password_matched(password_matched), .isPaidCash(isPaidCash),
    .isPaidCard(isPaidCard), .result(result), .alarm_status(alarm_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference: fees and totals as plain integers clipped at 255.
  task automatic model();
    int f1, f2, f3, tot, due, res;
    logic [7:0] rev;
    logic pm, pc, pk, lock;
    f1  = min255(int'(WEIGHT > WEIGHT_THRESHOLD ? PRICE_2 : PRICE_1) * int'(hours) + int'(additional));
    f2  = min255(int'(power > CHARGE_THRESHOLD ? FAST_CHARGE_PRICE : CHARGE_PRICE) * int'(duration) + int'(additional));
    f3  = min255(int'(capacity > CAPACITY_THRESHOLD ? HIGH_CAPACITY_PRICE : SMALL_CAPACITY_PRICE) * int'(hours) + int'(additional));
    tot = min255(f1 + f2 + f3);
    pm  = (user_password == PASSWORD);
    exp_alarm = (int'(temp) >= 12) ? 8'hFF : firePosition;
    due = (code == 3'd1) ? f1 : (code == 3'd2) ? f2 : (code == 3'd3) ? f3 :
          (code == 3'd4 || code == 3'd6) ? tot : 0;
    pc  = (due != 0) && (int'(cash) >= due);
    pk  = (due != 0) && !pc && (card_number != 0);
    rev = {<<{PARK_SEQUENCE}};
    case (code)
      3'd1: res = f1;
      3'd2: res = f2;
      3'd3: res = f3;
      3'd4: res = tot;
      3'd5: res = reverse ? int'(rev) : int'(PARK_SEQUENCE);
      3'd6: res = (int'(cash) >= tot) ? int'(cash) - tot : 0;
      3'd7: res = (pm ? 128 : 0) + ((exp_alarm != 0) ? 64 : 0);
      default: res = 0;
    endcase
`ifdef ALARM_LOCKOUT_EN
    lock = (exp_alarm != 0);
`else
    lock = 1'b0;
`endif
    exp_pm     = pm;
    exp_result = (pm && !lock) ? 8'(res) : 8'h00;
    exp_cash   = pm && !lock && pc;
    exp_card   = pm && !lock && pk;
  endtask

  task automatic step_check(input string tag);
    @(posedge clk);
    #1;
    model();
    chk({tag, ".pm"},     {7'b0, password_matched}, {7'b0, exp_pm});
    chk({tag, ".cash"},   {7'b0, isPaidCash},       {7'b0, exp_cash});
    chk({tag, ".card"},   {7'b0, isPaidCard},       {7'b0, exp_card});
    chk({tag, ".result"}, result,                   exp_result);
    chk({tag, ".alarm"},  alarm_status,             exp_alarm);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".pm"},     {7'b0, password_matched}, 8'h00);
    chk({tag, ".cash"},   {7'b0, isPaidCash},       8'h00);
    chk({tag, ".card"},   {7'b0, isPaidCard},       8'h00);
    chk({tag, ".result"}, result,                   8'h00);
    chk({tag, ".alarm"},  alarm_status,             8'h00);
  endtask

  initial begin
    rst = 1'b1;
    PRICE_1 = 4'd1; PRICE_2 = 4'd2; WEIGHT_THRESHOLD = 4'd4; WEIGHT = 4'd6;
    CHARGE_PRICE = 4'd1; FAST_CHARGE_PRICE = 4'd2; CHARGE_THRESHOLD = 4'd4;
    SMALL_CAPACITY_PRICE = 4'd1; HIGH_CAPACITY_PRICE = 4'd2; CAPACITY_THRESHOLD = 4'd4;
    PASSWORD = 4'b1101; PARK_SEQUENCE = 8'hCC;
    temp = 4'd0; firePosition = 8'h00; duration = 4'd5; power = 4'd3; capacity = 4'd0;
    user_password = 4'b1100; cash = 8'h00; card_number = 4'd0; additional = 8'h20;
    code = 3'b010; hours = 4'd3; reverse = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;

    // Wrong password blanks result and payment flags.
    step_check("badpw");
    chk("badpw.hard", result, 8'h00);

    user_password = 4'b1101;
    code = 3'b001; step_check("fee1"); chk("fee1.hard", result, 8'h26);
    code = 3'b010; step_check("fee2"); chk("fee2.hard", result, 8'h25);
    code = 3'b011; step_check("fee3"); chk("fee3.hard", result, 8'h23);
    code = 3'b100; step_check("total"); chk("total.hard", result, 8'h6E);

    cash = 8'h80;
    code = 3'b100; step_check("paycash"); chk("paycash.hard", {7'b0, isPaidCash}, 8'h01);
    code = 3'b110; step_check("change"); chk("change.hard", result, 8'h12);

    cash = 8'h00; card_number = 4'd6;
    code = 3'b100; step_check("paycard"); chk("paycard.hard", {7'b0, isPaidCard}, 8'h01);

    code = 3'b101; reverse = 1'b0; step_check("park"); chk("park.hard", result, 8'hCC);
    reverse = 1'b1; step_check("parkrev"); chk("parkrev.hard", result, 8'h33);

    code = 3'b000; step_check("idle");
    code = 3'b111; step_check("diag");

    // Equal-to-threshold picks the low rate.
    WEIGHT = 4'd4; power = 4'd4; capacity = 4'd4;
    code = 3'b001; step_check("eq1");
    code = 3'b010; step_check("eq2");
    code = 3'b011; step_check("eq3");

    // Saturation of the surcharge add and of the total.
    additional = 8'hF0; WEIGHT = 4'd15; hours = 4'd15;
    code = 3'b001; step_check("sat1"); chk("sat1.hard", result, 8'hFF);
    code = 3'b100; step_check("satt");
    additional = 8'h20; WEIGHT = 4'd6; hours = 4'd3; power = 4'd3; capacity = 4'd0;

    firePosition = 8'h40; code = 3'b001;
    step_check("fire"); chk("fire.hard", alarm_status, 8'h40);
    code = 3'b111; step_check("firediag");
    firePosition = 8'h00; temp = 4'd13;
    step_check("hot"); chk("hot.hard", alarm_status, 8'hFF);
    temp = 4'd12; step_check("templimit");
    temp = 4'd11; step_check("tempbelow");

    // Asynchronous reset between clock edges.
    code = 3'b100; cash = 8'h80; firePosition = 8'h01;
    step_check("prerst");
    #2 rst = 1'b1;
    #1 all_zero("midrst");
    @(posedge clk); #1 all_zero("rsthold");
    rst = 1'b0;
    step_check("postrst");

    for (int i = 0; i < 80; i++) begin
      PRICE_1 = 4'($urandom); PRICE_2 = 4'($urandom); WEIGHT_THRESHOLD = 4'($urandom);
      FAST_CHARGE_PRICE = 4'($urandom); CHARGE_PRICE = 4'($urandom);
      CHARGE_THRESHOLD = 4'($urandom); HIGH_CAPACITY_PRICE = 4'($urandom);
      SMALL_CAPACITY_PRICE = 4'($urandom); CAPACITY_THRESHOLD = 4'($urandom);
      PASSWORD = 4'($urandom); WEIGHT = 4'($urandom);
      temp = 4'($urandom); duration = 4'($urandom); power = 4'($urandom);
      capacity = 4'($urandom); hours = 4'($urandom);
      user_password = ($urandom_range(0, 3) != 0) ? PASSWORD : 4'($urandom);
      firePosition = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cash = 8'($urandom); card_number = 4'($urandom_range(0, 2));
      additional = 8'($urandom_range(0, 80));
      PARK_SEQUENCE = 8'($urandom); code = 3'($urandom); reverse = 1'($urandom);
      step_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_circuit.md
MAIN_CIRCUIT -- requirements
Module: main_circuit

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst input 1 reset, asynchronous, active-high.
REQ-002 SHALL have 4-bit tariff inputs: PRICE_1, PRICE_2, WEIGHT_THRESHOLD, FAST_CHARGE_PRICE, CHARGE_PRICE, CHARGE_THRESHOLD, HIGH_CAPACITY_PRICE, SMALL_CAPACITY_PRICE, CAPACITY_THRESHOLD, PASSWORD, WEIGHT.
REQ-003 SHALL have other inputs: temp 4 temperature; firePosition 8 per-zone fire flags; duration 4 charge time; power 4 charger power; capacity 4 storage size; user_password 4; cash 8 cash tendered; card_number 4 (0 = no card); PARK_SEQUENCE 8 slot pattern; additional 8 surcharge; code 3 operation select; hours 4 parking time; reverse 1.
REQ-004 SHALL have outputs: password_matched 1; isPaidCash 1; isPaidCard 1; result 8; alarm_status 8.

Function
REQ-005 All outputs SHALL be registered: inputs sampled on rising clk, outputs valid after that edge (1-cycle latency).
REQ-006 password_matched SHALL be 1 iff user_password == PASSWORD.
REQ-007 alarm_status SHALL be firePosition, or 8'hFF when temp >= TEMP_LIMIT (4'd12).
REQ-008 fee1 = (WEIGHT > WEIGHT_THRESHOLD ? PRICE_2 : PRICE_1) * hours + additional.
REQ-009 fee2 = (power > CHARGE_THRESHOLD ? FAST_CHARGE_PRICE : CHARGE_PRICE) * duration + additional.
REQ-010 fee3 = (capacity > CAPACITY_THRESHOLD ? HIGH_CAPACITY_PRICE : SMALL_CAPACITY_PRICE) * hours + additional.
REQ-011 Products SHALL be 8-bit unsigned; all sums SHALL saturate at 8'hFF; total = fee1+fee2+fee3 (saturating).
REQ-012 result by code: 000 -> 0; 001 -> fee1; 010 -> fee2; 011 -> fee3; 100 -> total; 101 -> PARK_SEQUENCE, bit-reversed when reverse=1; 110 -> cash - total if cash >= total, else 0; 111 -> {password_matched, |alarm_status, isPaidCash, isPaidCard, 4'b0} using current-cycle values.
REQ-013 due = fee of codes 001-011, total for 100 and 110, else 0.
REQ-014 isPaidCash SHALL be 1 iff due != 0 and cash >= due.
REQ-015 isPaidCard SHALL be 1 iff due != 0, isPaidCash = 0 and card_number != 0.
REQ-016 When password_matched = 0: result, isPaidCash and isPaidCard SHALL be 0; alarm_status remains active.
REQ-017 Comparisons are strict greater-than; value equal to threshold selects the low rate.

Reset
REQ-018 rst = 1 SHALL immediately clear all outputs to 0, independent of clk.
REQ-019 On deassertion, outputs SHALL update from the first subsequent rising clk; reset mid-operation discards the pending result.

Configuration
REQ-020 Macro ALARM_LOCKOUT_EN: when defined, nonzero alarm_status SHALL force result, isPaidCash, isPaidCard to 0; when undefined, alarms are report-only and do not affect the other outputs.

Structure
REQ-021 A shared package SHALL hold code encodings (CODE_IDLE..CODE_DIAG) and TEMP_LIMIT.
REQ-022 One sub-module, tariff_calc (threshold select, multiply, saturating add), SHALL be instantiated three times for fee1..fee3.

Verification
Tariffs for all scenarios: PRICE_1=1, PRICE_2=2, WEIGHT_THRESHOLD=4, WEIGHT=6, CHARGE_PRICE=1, FAST_CHARGE_PRICE=2, CHARGE_THRESHOLD=4, SMALL=1, HIGH=2, CAPACITY_THRESHOLD=4, PASSWORD=1101, PARK_SEQUENCE=8'hCC.
REQ-023 user_password=1100, code=010 -> password_matched=0, result=0, isPaidCash=0, isPaidCard=0.
REQ-024 Password ok, hours=3, additional=8'h20, duration=5, power=3, capacity=0: code 001 -> 8'h26; code 010 -> 8'h25; code 011 -> 8'h23; code 100 -> 8'h6E.
REQ-025 Same inputs plus cash=8'h80: code 100 -> isPaidCash=1, isPaidCard=0; code 110 -> result=8'h12.
REQ-026 Same inputs, cash=0, card_number=6, code 100 -> isPaidCash=0, isPaidCard=1.
REQ-027 code=101: reverse=0 -> 8'hCC; reverse=1 -> 8'h33.
REQ-028 firePosition=8'h40 -> alarm_status=8'h40, result=0 with ALARM_LOCKOUT_EN; temp=13 -> alarm_status=8'hFF; rst pulse mid-run -> all outputs 0 immediately.
